xpu_vpu_pc_tn_vlsu_ld_nan_canon: RTL and testbench

Load-data floating-point NaN canonicalization stage in the VLSU return path. It sits downstream of the per-element IEEE-754 NaN detector and consumes its `is_nan` results for every element lane of a returned load beat. It marks NaN elements, optionally replaces them with the canonical quiet NaN, and keeps a saturating per-instruction NaN count. It is a one-register pipeline stage with a skid buffer and valid/ready handshakes on both sides.

---
 rtl/xpu_vpu_pc_tn_vlsu_pkg.sv | 39 +++
 rtl/xpu_vpu_pc_tn_vlsu_ld_nan_lane.sv | 75 +++++++
 rtl/xpu_vpu_pc_tn_vlsu_ld_nan_canon.sv | 137 +++++++++++++
 tb/tb_xpu_vpu_pc_tn_vlsu_ld_nan_canon.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/xpu_vpu_pc_tn_vlsu_pkg.sv
// Shared VLSU definitions: SEW encodings, FP field sizes, canonical NaNs and
// the per-format NaN detector used by the load-data canonicalization stage.
package xpu_vpu_pc_tn_vlsu_pkg;

    typedef enum logic [1:0] {
        SEW_8  = 2'b00,
        SEW_16 = 2'b01,
        SEW_32 = 2'b10,
        SEW_64 = 2'b11
    } sew_e;

    localparam int H_EXP_W = 5;
    localparam int H_MAN_W = 10;
    localparam int S_EXP_W = 8;
    localparam int S_MAN_W = 23;
    localparam int D_EXP_W = 11;
    localparam int D_MAN_W = 52;

    localparam logic [15:0] CANON_NAN_H = 16'h7E00;
    localparam logic [31:0] CANON_NAN_S = 32'h7FC0_0000;
    localparam logic [63:0] CANON_NAN_D = 64'h7FF8_0000_0000_0000;

    // A 64-bit slice holds at most four NaN elements.
    localparam int LANE_CNT_W = 3;

    // Sign bit is excluded: all-ones exponent with nonzero mantissa is NaN.
    function automatic logic is_nan_h(input logic [H_EXP_W+H_MAN_W-1:0] e);
        return (&e[H_MAN_W +: H_EXP_W]) && (|e[H_MAN_W-1:0]);
    endfunction

    function automatic logic is_nan_s(input logic [S_EXP_W+S_MAN_W-1:0] e);
        return (&e[S_MAN_W +: S_EXP_W]) && (|e[S_MAN_W-1:0]);
    endfunction

    function automatic logic is_nan_d(input logic [D_EXP_W+D_MAN_W-1:0] e);
        return (&e[D_MAN_W +: D_EXP_W]) && (|e[D_MAN_W-1:0]);
    endfunction

endpackage

// File: rtl/xpu_vpu_pc_tn_vlsu_ld_nan_lane.sv
// One 64-bit slice of the NaN canonicalizer: detects NaNs for every element
// width, selects by SEW, and emits data, NaN byte mask and NaN count.
// Replacement with the canonical NaN only when XPU_VPU_VLSU_NAN_CANON_EN is defined.
module xpu_vpu_pc_tn_vlsu_ld_nan_lane
    import xpu_vpu_pc_tn_vlsu_pkg::*;
(
    input  logic [63:0]           data_i,
    input  logic [7:0]            be_i,
    input  logic [1:0]            sew_i,
    input  logic                  fp_i,
    output logic [63:0]           data_o,
    output logic [7:0]            nan_be_o,
    output logic [LANE_CNT_W-1:0] nan_cnt_o
);

    logic [3:0] h_nan;
    logic [1:0] s_nan;
    logic       d_nan;

    // Activity is decided by the element's lowest byte enable only.
    logic unused_be;
    assign unused_be = ^{be_i[7], be_i[5], be_i[3], be_i[1]};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            h_nan[i] = fp_i && be_i[2*i] && is_nan_h(data_i[16*i +: 15]);
        end
        for (int i = 0; i < 2; i++) begin
            s_nan[i] = fp_i && be_i[4*i] && is_nan_s(data_i[32*i +: 31]);
        end
        d_nan = fp_i && be_i[0] && is_nan_d(data_i[62:0]);
    end

    always_comb begin
        data_o    = data_i;
        nan_be_o  = '0;
        nan_cnt_o = '0;
        case (sew_e'(sew_i))
            SEW_16: begin
                for (int i = 0; i < 4; i++) begin
                    if (h_nan[i]) begin
                        nan_be_o[2*i +: 2] = 2'b11;
                        nan_cnt_o          = nan_cnt_o + LANE_CNT_W'(1);
`ifdef XPU_VPU_VLSU_NAN_CANON_EN
                        data_o[16*i +: 16] = CANON_NAN_H;
`endif
                    end
                end
            end
            SEW_32: begin
                for (int i = 0; i < 2; i++) begin
                    if (s_nan[i]) begin
                        nan_be_o[4*i +: 4] = 4'hF;
                        nan_cnt_o          = nan_cnt_o + LANE_CNT_W'(1);
`ifdef XPU_VPU_VLSU_NAN_CANON_EN
                        data_o[32*i +: 32] = CANON_NAN_S;
`endif
                    end
                end
            end
            SEW_64: begin
                if (d_nan) begin
                    nan_be_o  = 8'hFF;
                    nan_cnt_o = LANE_CNT_W'(1);
`ifdef XPU_VPU_VLSU_NAN_CANON_EN
                    data_o    = CANON_NAN_D;
`endif
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/xpu_vpu_pc_tn_vlsu_ld_nan_canon.sv
// VLSU load-return NaN canonicalization stage: output register plus skid
// buffer, saturating NaN counter and done pulse. Macro: XPU_VPU_VLSU_NAN_CANON_EN.
module xpu_vpu_pc_tn_vlsu_ld_nan_canon #(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    ld_beat_vld,
    output logic                    ld_beat_rdy,
    input  logic [DATA_WIDTH-1:0]   ld_beat_data,
    input  logic [1:0]              ld_beat_sew,
    input  logic                    ld_beat_fp,
    input  logic [DATA_WIDTH/8-1:0] ld_beat_be,
    input  logic                    ld_beat_last,
    output logic                    canon_vld,
    input  logic                    canon_rdy,
    output logic [DATA_WIDTH-1:0]   canon_data,
    output logic [DATA_WIDTH/8-1:0] canon_nan_be,
    output logic                    canon_last,
    input  logic                    nan_cnt_clr,
    output logic [CNT_WIDTH-1:0]    nan_cnt,
    output logic                    nan_cnt_done
);

    import xpu_vpu_pc_tn_vlsu_pkg::*;

    localparam int NSLICE = DATA_WIDTH / 64;
    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int SUM_W  = $clog2(DATA_WIDTH / 16 + 1);
    localparam int ADD_W  = ((CNT_WIDTH > SUM_W) ? CNT_WIDTH : SUM_W) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [BE_W-1:0]       nan_be;
        logic                  last;
    } beat_t;

    logic [DATA_WIDTH-1:0] proc_data;
    logic [BE_W-1:0]       proc_be;
    logic [LANE_CNT_W-1:0] slice_cnt [NSLICE];
    logic [SUM_W-1:0]      beat_cnt;

    for (genvar s = 0; s < NSLICE; s++) begin : g_slice
        xpu_vpu_pc_tn_vlsu_ld_nan_lane u_lane (
            .data_i    (ld_beat_data[64*s +: 64]),
            .be_i      (ld_beat_be[8*s +: 8]),
            .sew_i     (ld_beat_sew),
            .fp_i      (ld_beat_fp),
            .data_o    (proc_data[64*s +: 64]),
            .nan_be_o  (proc_be[8*s +: 8]),
            .nan_cnt_o (slice_cnt[s])
        );
    end

    always_comb begin
        beat_cnt = '0;
        for (int s = 0; s < NSLICE; s++) begin
            beat_cnt = beat_cnt + SUM_W'(slice_cnt[s]);
        end
    end

    beat_t out_q, out_d, skid_q, skid_d, in_beat;
    logic  out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic  done_q, done_d;
    logic  [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_base;
    logic  [ADD_W-1:0]     cnt_sum;
    logic  in_hs, out_hs;

    // Ready depends only on skid occupancy, so canon_rdy never reaches ld_beat_rdy.
    assign in_hs  = ld_beat_vld && !skid_vld_q;
    assign out_hs = out_vld_q && canon_rdy;

    always_comb begin
        in_beat    = '{data: proc_data, nan_be: proc_be, last: ld_beat_last};
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!out_vld_q || canon_rdy) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else if (in_hs) begin
                out_d     = in_beat;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (in_hs) begin
            skid_d     = in_beat;
            skid_vld_d = 1'b1;
        end
    end

    // Clear wins first, then the accepted beat is added with saturation.
    always_comb begin
        cnt_base = nan_cnt_clr ? '0 : cnt_q;
        cnt_sum  = ADD_W'(cnt_base) + ADD_W'(beat_cnt);
        cnt_d    = cnt_q;
        if (in_hs) begin
            cnt_d = (cnt_sum > ADD_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_WIDTH-1:0];
        end else if (nan_cnt_clr) begin
            cnt_d = '0;
        end
        done_d = out_hs && out_q.last;
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
        end
    end

    assign ld_beat_rdy  = !skid_vld_q;
    assign canon_vld    = out_vld_q;
    assign canon_data   = out_q.data;
    assign canon_nan_be = out_q.nan_be;
    assign canon_last   = out_q.last;
    assign nan_cnt      = cnt_q;
    assign nan_cnt_done = done_q;

endmodule

// File: tb/tb_xpu_vpu_pc_tn_vlsu_ld_nan_canon.sv
// Directed bench for the NaN canonicalization stage (128-bit beats, 3-bit counter).
// Expected data follows XPU_VPU_VLSU_NAN_CANON_EN as defined for the build.
module tb_xpu_vpu_pc_tn_vlsu_ld_nan_canon;

    logic         forever_cpuclk;
    logic         cpurst_b;
    logic         ld_beat_vld;
    logic         ld_beat_rdy;
    logic [127:0] ld_beat_data;
    logic [1:0]   ld_beat_sew;
    logic         ld_beat_fp;
    logic [15:0]  ld_beat_be;
    logic         ld_beat_last;
    logic         canon_vld;
    logic         canon_rdy;
    logic [127:0] canon_data;
    logic [15:0]  canon_nan_be;
    logic         canon_last;
    logic         nan_cnt_clr;
    logic [2:0]   nan_cnt;
    logic         nan_cnt_done;

    int vecCount  = 0;
    int missCount = 0;

    xpu_vpu_pc_tn_vlsu_ld_nan_canon #(.DATA_WIDTH(128), .CNT_WIDTH(3)) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .ld_beat_vld    (ld_beat_vld),
        .ld_beat_rdy    (ld_beat_rdy),
        .ld_beat_data   (ld_beat_data),
        .ld_beat_sew    (ld_beat_sew),
        .ld_beat_fp     (ld_beat_fp),
        .ld_beat_be     (ld_beat_be),
        .ld_beat_last   (ld_beat_last),
        .canon_vld      (canon_vld),
        .canon_rdy      (canon_rdy),
        .canon_data     (canon_data),
        .canon_nan_be   (canon_nan_be),
        .canon_last     (canon_last),
        .nan_cnt_clr    (nan_cnt_clr),
        .nan_cnt        (nan_cnt),
        .nan_cnt_done   (nan_cnt_done)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    task automatic tick();
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic applyStimulus(input logic vld, input logic [127:0] data, input logic [1:0] sew,
                                 input logic fp, input logic [15:0] be, input logic last);
        ld_beat_vld  = vld;
        ld_beat_data = data;
        ld_beat_sew  = sew;
        ld_beat_fp   = fp;
        ld_beat_be   = be;
        ld_beat_last = last;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " canon_vld"}, 128'(canon_vld), 128'(1'b0));
        checkOutput({tag, " canon_data"}, canon_data, 128'h0);
        checkOutput({tag, " canon_nan_be"}, 128'(canon_nan_be), 128'h0);
        checkOutput({tag, " canon_last"}, 128'(canon_last), 128'(1'b0));
        checkOutput({tag, " nan_cnt"}, 128'(nan_cnt), 128'h0);
        checkOutput({tag, " nan_cnt_done"}, 128'(nan_cnt_done), 128'(1'b0));
        checkOutput({tag, " ld_beat_rdy"}, 128'(ld_beat_rdy), 128'(1'b1));
    endtask

    logic [127:0] t1Data, t1Exp, t2Data, t2Exp, hSatData, hSatExp, h2Data, h2Exp;

    initial begin
        t1Data   = 128'hFFC12345_3F800000_7F800000_7F800001;
        t2Data   = 128'h7FF0000000000001_7FF0000000000002;
        hSatData = {8{16'h7C01}};
        h2Data   = 128'h0000_0000_0000_0000_FFFF_3C00_7C00_7D00;
`ifdef XPU_VPU_VLSU_NAN_CANON_EN
        t1Exp    = 128'h7FC00000_3F800000_7F800000_7FC00000;
        t2Exp    = 128'h7FF0000000000001_7FF8000000000000;
        hSatExp  = {8{16'h7E00}};
        h2Exp    = 128'h0000_0000_0000_0000_7E00_3C00_7C00_7E00;
`else
        t1Exp    = t1Data;
        t2Exp    = t2Data;
        hSatExp  = hSatData;
        h2Exp    = h2Data;
`endif

        cpurst_b    = 1'b0;
        canon_rdy   = 1'b1;
        nan_cnt_clr = 1'b0;
        applyStimulus(1'b0, '0, 2'b00, 1'b0, '0, 1'b0);
        #12;
        checkResetState("reset");
        tick();
        cpurst_b = 1'b1;
        tick();

        // Single precision, mixed lanes
        applyStimulus(1'b1, t1Data, 2'b10, 1'b1, 16'hFFFF, 1'b0);
        tick();
        checkOutput("t1 canon_vld", 128'(canon_vld), 128'(1'b1));
        checkOutput("t1 canon_data", canon_data, t1Exp);
        checkOutput("t1 canon_nan_be", 128'(canon_nan_be), 128'hF00F);
        checkOutput("t1 nan_cnt", 128'(nan_cnt), 128'd2);

        // Same data, not an FP load
        applyStimulus(1'b1, t1Data, 2'b10, 1'b0, 16'hFFFF, 1'b0);
        tick();
        checkOutput("nofp canon_data", canon_data, t1Data);
        checkOutput("nofp canon_nan_be", 128'(canon_nan_be), 128'h0);
        checkOutput("nofp nan_cnt", 128'(nan_cnt), 128'd2);

        // Double precision, lane1 inactive
        applyStimulus(1'b1, t2Data, 2'b11, 1'b1, 16'hFEFF, 1'b0);
        tick();
        checkOutput("inact canon_data", canon_data, t2Exp);
        checkOutput("inact canon_nan_be", 128'(canon_nan_be), 128'h00FF);
        checkOutput("inact nan_cnt", 128'(nan_cnt), 128'd3);

        // SEW 8 never holds FP elements
        applyStimulus(1'b1, {128{1'b1}}, 2'b00, 1'b1, 16'hFFFF, 1'b0);
        tick();
        checkOutput("sew8 canon_data", canon_data, {128{1'b1}});
        checkOutput("sew8 canon_nan_be", 128'(canon_nan_be), 128'h0);
        checkOutput("sew8 nan_cnt", 128'(nan_cnt), 128'd3);
        checkOutput("sew8 nan_cnt_done", 128'(nan_cnt_done), 128'(1'b0));

        // Clear without a beat
        applyStimulus(1'b0, '0, 2'b00, 1'b0, '0, 1'b0);
        nan_cnt_clr = 1'b1;
        tick();
        nan_cnt_clr = 1'b0;
        checkOutput("clr nan_cnt", 128'(nan_cnt), 128'd0);
        checkOutput("clr canon_vld", 128'(canon_vld), 128'(1'b0));

        // Eight half NaNs saturate a 3-bit counter
        applyStimulus(1'b1, hSatData, 2'b01, 1'b1, 16'hFFFF, 1'b0);
        tick();
        checkOutput("sat canon_data", canon_data, hSatExp);
        checkOutput("sat canon_nan_be", 128'(canon_nan_be), 128'hFFFF);
        checkOutput("sat nan_cnt", 128'(nan_cnt), 128'd7);

        // Clear together with a 2-NaN beat
        applyStimulus(1'b1, h2Data, 2'b01, 1'b1, 16'hFFFF, 1'b0);
        nan_cnt_clr = 1'b1;
        tick();
        nan_cnt_clr = 1'b0;
        checkOutput("clrbeat canon_data", canon_data, h2Exp);
        checkOutput("clrbeat canon_nan_be", 128'(canon_nan_be), 128'h00C3);
        checkOutput("clrbeat nan_cnt", 128'(nan_cnt), 128'd2);

        // Done pulse follows the output handshake of the last beat
        applyStimulus(1'b1, 128'h1234, 2'b10, 1'b0, 16'hFFFF, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 2'b00, 1'b0, '0, 1'b0);
        checkOutput("done canon_last", 128'(canon_last), 128'(1'b1));
        checkOutput("done early", 128'(nan_cnt_done), 128'(1'b0));
        tick();
        checkOutput("done pulse", 128'(nan_cnt_done), 128'(1'b1));
        checkOutput("done drained", 128'(canon_vld), 128'(1'b0));
        tick();
        checkOutput("done width", 128'(nan_cnt_done), 128'(1'b0));

        // Backpressure: three stalled cycles, two beats accepted
        canon_rdy = 1'b0;
        applyStimulus(1'b1, {32{4'hA}}, 2'b10, 1'b0, 16'hFFFF, 1'b0);
        tick();
        checkOutput("bp1 ld_beat_rdy", 128'(ld_beat_rdy), 128'(1'b1));
        checkOutput("bp1 canon_data", canon_data, {32{4'hA}});
        applyStimulus(1'b1, {32{4'hB}}, 2'b10, 1'b0, 16'hFFFF, 1'b0);
        tick();
        checkOutput("bp2 ld_beat_rdy", 128'(ld_beat_rdy), 128'(1'b0));
        applyStimulus(1'b1, {32{4'hC}}, 2'b10, 1'b0, 16'hFFFF, 1'b0);
        tick();
        checkOutput("bp3 ld_beat_rdy", 128'(ld_beat_rdy), 128'(1'b0));
        checkOutput("bp3 canon_data", canon_data, {32{4'hA}});
        canon_rdy = 1'b1;
        tick();
        checkOutput("bp4 canon_data", canon_data, {32{4'hB}});
        checkOutput("bp4 ld_beat_rdy", 128'(ld_beat_rdy), 128'(1'b1));
        tick();
        checkOutput("bp5 canon_data", canon_data, {32{4'hC}});
        checkOutput("bp5 canon_vld", 128'(canon_vld), 128'(1'b1));
        applyStimulus(1'b0, '0, 2'b00, 1'b0, '0, 1'b0);
        tick();
        checkOutput("bp6 canon_vld", 128'(canon_vld), 128'(1'b0));

        // Reset with output and skid both full
        canon_rdy = 1'b0;
        applyStimulus(1'b1, t1Data, 2'b10, 1'b1, 16'hFFFF, 1'b0);
        tick();
        applyStimulus(1'b1, t1Data, 2'b10, 1'b1, 16'hFFFF, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 2'b00, 1'b0, '0, 1'b0);
        checkOutput("full ld_beat_rdy", 128'(ld_beat_rdy), 128'(1'b0));
        checkOutput("full nan_cnt", 128'(nan_cnt), 128'd6);
        #2;
        cpurst_b = 1'b0;
        #1;
        checkResetState("midrst");
        tick();
        cpurst_b  = 1'b1;
        canon_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("midrst no done", 128'(nan_cnt_done), 128'(1'b0));
            checkOutput("midrst no beat", 128'(canon_vld), 128'(1'b0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
